dmem_ctrl: RTL

Parametrised, multi-cycle data memory for the pipelined MIPS datapath's MEM stage. It services one load or store at a time through a valid/ready request port and a one-cycle response pulse. It supports byte, halfword and word accesses with sign or zero extension, and a configurable number of wait states. Optionally it flags misaligned and out-of-window accesses as faults for the hazard/exception logic.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and the load-extension helper for dmem_ctrl.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h7FFF_F000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } dmem_state_t;

  // Move the addressed byte/half down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-byte write mask; write and registered read share one enable.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       wmask,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (wmask[0]) mem[idx][7:0]   <= wdata[7:0];
        if (wmask[1]) mem[idx][15:8]  <= wdata[15:8];
        if (wmask[2]) mem[idx][23:16] <= wdata[23:16];
        if (wmask[3]) mem[idx][31:24] <= wdata[31:24];
      end
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle byte/half/word data memory for the MEM stage (IDLE/WAIT/ACCESS/RESP).
// Define DMEM_FAULT_EN to reject illegal-size, misaligned and out-of-window accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        load_ok_q, load_ok_d;
  logic        fault_q, fault_d;
  logic [1:0]  rsp_size_q, rsp_size_d;
  logic [1:0]  rsp_lane_q, rsp_lane_d;
  logic        rsp_signed_q, rsp_signed_d;

  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             fault;
  logic [3:0]       wmask;
  logic [31:0]      wdata_lanes;
  logic             mem_en;
  logic             accept;
  logic [31:0]      mem_rdata;
  logic             unused_offset;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_fault = fault_q;
  assign rsp_rdata = load_ok_q ? load_extend(mem_rdata, rsp_size_q, rsp_lane_q, rsp_signed_q) : 32'h0;

  // Address decode, lane steering and fault checks on the latched request.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    word_idx = offset[IDX_W+1:2];
    lane     = addr_q[1:0];
    fault    = 1'b0;
`ifdef DMEM_FAULT_EN
    case (size_q)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = lane[0];
      SZ_WORD: fault = (lane != 2'b00);
      default: fault = 1'b1;
    endcase
    if ((addr_q < BASE_ADDR) || ({2'b00, offset[31:2]} >= DEPTH)) fault = 1'b1;
`endif
    case (size_q)
      SZ_BYTE: begin
        wmask       = 4'b0001 << lane;
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        wmask       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask       = 4'b1111;
        wdata_lanes = wdata_q;
      end
    endcase
    mem_en = (state_q == ST_ACCESS) && !reset && !fault;
  end

`ifdef DMEM_FAULT_EN
  assign unused_offset = ^offset[1:0];
`else
  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_ok_d    = load_ok_q;
    fault_d      = fault_q;
    rsp_size_d   = rsp_size_q;
    rsp_lane_d   = rsp_lane_q;
    rsp_signed_d = rsp_signed_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = WS_INIT;
          state_d  = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        // Capture everything the response needs so it holds until the next one.
        state_d      = ST_RESP;
        fault_d      = fault;
        load_ok_d    = !write_q && !fault;
        rsp_size_d   = size_q;
        rsp_lane_d   = lane;
        rsp_signed_d = signed_q;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      load_ok_q    <= 1'b0;
      fault_q      <= 1'b0;
      rsp_size_q   <= 2'b00;
      rsp_lane_q   <= 2'b00;
      rsp_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      load_ok_q    <= load_ok_d;
      fault_q      <= fault_d;
      rsp_size_q   <= rsp_size_d;
      rsp_lane_q   <= rsp_lane_d;
      rsp_signed_q <= rsp_signed_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (write_q),
    .wmask (wmask),
    .idx   (word_idx),
    .wdata (wdata_lanes),
    .rdata (mem_rdata)
  );

endmodule
